// File: rtl/if_id_pipe_buf_pkg.sv
// Shared definitions for the in-order pipeline stage buffers.
// IF/ID, ID/EX and later boundary registers reuse these widths and types.
package riscv_pipe_pkg;

  // Default datapath widths shared by all stage buffers.
  localparam int DEF_INS_W = 32;
  localparam int DEF_PC_W  = 64;

  // addi x0,x0,0: the bubble presented to decode whenever a slot is empty.
  localparam logic [DEF_INS_W-1:0] NOP_INSN = 32'h0000_0013;

  // One fetched beat as it travels from fetch to decode.
  typedef struct packed {
    logic [DEF_INS_W-1:0] ins;
    logic [DEF_PC_W-1:0]  pc;
  } if_id_payload_t;

  // Buffer occupancy: nothing, main slot only, main plus skid slot.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } if_id_occ_e;

endpackage

// File: rtl/if_id_pipe_buf_if.sv
// Fetch-side handshake and decode-side beat bundle of the IF/ID buffer.
// master: the fetch/decode environment; slave: the buffer itself.
interface if_id_pipe_buf_if #(
  parameter int INS_W = riscv_pipe_pkg::DEF_INS_W,
  parameter int PC_W  = riscv_pipe_pkg::DEF_PC_W
);

  // Fetch side
  logic             in_valid;
  logic             in_ready;
  logic [INS_W-1:0] in_ins;
  logic [PC_W-1:0]  in_pc;

  // Decode side
  logic             out_valid;
  logic [INS_W-1:0] out_ins;
  logic [PC_W-1:0]  out_pc;

  modport master (
    output in_valid,
    output in_ins,
    output in_pc,
    input  in_ready,
    input  out_valid,
    input  out_ins,
    input  out_pc
  );

  modport slave (
    input  in_valid,
    input  in_ins,
    input  in_pc,
    output in_ready,
    output out_valid,
    output out_ins,
    output out_pc
  );

endinterface

// File: rtl/if_id_pipe_buf_skid_slot.sv
// One payload register (instruction + PC) with its valid bit.
// clear beats load so a flush always wins; an empty slot holds the
// NOP/zero pattern, letting the owner drive outputs straight from flops.
module if_id_skid_slot #(
  parameter int               INS_W     = 32,
  parameter int               PC_W      = 64,
  parameter logic [INS_W-1:0] EMPTY_INS = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [INS_W-1:0] d_ins,
  input  logic [PC_W-1:0]  d_pc,
  output logic             valid_reg,
  output logic [INS_W-1:0] ins_reg,
  output logic [PC_W-1:0]  pc_reg
);

  // Slot contents: clear to the empty pattern, load a beat, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      ins_reg   <= EMPTY_INS;
      pc_reg    <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
      ins_reg   <= EMPTY_INS;
      pc_reg    <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      ins_reg   <= d_ins;
      pc_reg    <= d_pc;
    end
  end

endmodule

// File: rtl/if_id_pipe_buf.sv
// IF/ID boundary register with a valid/ready handshake toward fetch,
// a two-entry (main + skid) buffer and flush-to-NOP.
// Optional build macro IF_ID_STALL_CNT_EN adds the 32-bit stall_cnt output
// counting cycles where decode holds a valid beat while stalled.
module if_id_pipe_buf #(
  parameter int               INS_W    = riscv_pipe_pkg::DEF_INS_W,
  parameter int               PC_W     = riscv_pipe_pkg::DEF_PC_W,
  parameter logic [INS_W-1:0] NOP_INSN = riscv_pipe_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            stall,
  if_id_pipe_buf_if.slave bus
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  riscv_pipe_pkg::if_id_occ_e state_reg, state_next;

  logic             in_ready_reg, in_ready_next;
  logic             accept, drain;
  logic             main_load, main_clear;
  logic             skid_load, skid_clear;
  logic             main_valid, skid_valid;
  logic [INS_W-1:0] main_ins, skid_ins, main_d_ins;
  logic [PC_W-1:0]  main_pc, skid_pc, main_d_pc;

  // in_ready is a flop, so accept never depends combinationally on stall.
  assign accept = bus.in_valid && in_ready_reg;
  assign drain  = main_valid && !stall;

  // The skid beat is older than anything arriving now, so it refills main first.
  assign main_d_ins = skid_valid ? skid_ins : bus.in_ins;
  assign main_d_pc  = skid_valid ? skid_pc  : bus.in_pc;

  // Occupancy register plus the registered ready toward fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= riscv_pipe_pkg::OCC_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= in_ready_next;
    end
  end

  // Next occupancy and slot load/clear strobes; flush overrides everything.
  always_comb begin
    state_next = state_reg;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_next = riscv_pipe_pkg::OCC_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_reg)
        riscv_pipe_pkg::OCC_EMPTY: begin
          if (accept) begin
            main_load  = 1'b1;
            state_next = riscv_pipe_pkg::OCC_ONE;
          end
        end
        riscv_pipe_pkg::OCC_ONE: begin
          if (drain) begin
            if (accept) begin
              // Back-to-back reload keeps full throughput.
              main_load = 1'b1;
            end else begin
              main_clear = 1'b1;
              state_next = riscv_pipe_pkg::OCC_EMPTY;
            end
          end else if (accept) begin
            // Decode is holding: park the in-flight beat in the skid slot.
            skid_load  = 1'b1;
            state_next = riscv_pipe_pkg::OCC_TWO;
          end
        end
        riscv_pipe_pkg::OCC_TWO: begin
          // in_ready is low here, so no accept can coincide.
          if (drain) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
            state_next = riscv_pipe_pkg::OCC_ONE;
          end
        end
        default: begin
          state_next = riscv_pipe_pkg::OCC_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
    // Ready whenever the skid slot will be free after this edge.
    in_ready_next = (state_next != riscv_pipe_pkg::OCC_TWO);
  end

  if_id_skid_slot #(
    .INS_W     (INS_W),
    .PC_W      (PC_W),
    .EMPTY_INS (NOP_INSN)
  ) u_main_slot (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (main_load),
    .clear     (main_clear),
    .d_ins     (main_d_ins),
    .d_pc      (main_d_pc),
    .valid_reg (main_valid),
    .ins_reg   (main_ins),
    .pc_reg    (main_pc)
  );

  if_id_skid_slot #(
    .INS_W     (INS_W),
    .PC_W      (PC_W),
    .EMPTY_INS (NOP_INSN)
  ) u_skid_slot (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .d_ins     (bus.in_ins),
    .d_pc      (bus.in_pc),
    .valid_reg (skid_valid),
    .ins_reg   (skid_ins),
    .pc_reg    (skid_pc)
  );

  // Main slot feeds decode directly; it already holds NOP/0 when empty.
  assign bus.out_valid = main_valid;
  assign bus.out_ins   = main_ins;
  assign bus.out_pc    = main_pc;
  assign bus.in_ready  = in_ready_reg;

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Count decode-stalled cycles with a valid beat held; wraps, survives flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
    end else if (main_valid && stall) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Bench for if_id_pipe_buf: directed scenarios with hand-computed cycle
// expectations plus a scoreboard monitor checking in-order, lossless delivery.
module tb_if_id_pipe_buf;
  import riscv_pipe_pkg::*;

  logic clk;
  logic reset_n;
  logic flush;
  logic stall;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  if_id_pipe_buf_if #(.INS_W(32), .PC_W(64)) bus ();

  if_id_pipe_buf dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .stall     (stall),
    .bus       (bus)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [63:0] pc);
    return 32'hA500_0000 | pc[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [63:0] pc);
    bus.in_valid = v;
    bus.in_pc    = v ? pc : 64'h0;
    bus.in_ins   = v ? ins_of(pc) : 32'h0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [63:0] pc, input logic rdy);
    check({tag, ".out_valid"}, bus.out_valid, v);
    check({tag, ".out_pc"},    bus.out_pc, v ? pc : 64'h0);
    check({tag, ".out_ins"},   bus.out_ins, v ? ins_of(pc) : NOP_INSN);
    check({tag, ".in_ready"},  bus.in_ready, rdy);
    $display("txn %s: valid=%0d pc=0x%0h ins=0x%08h ready=%0d",
             tag, bus.out_valid, bus.out_pc, bus.out_ins, bus.in_ready);
  endtask

  // Scoreboard: beats accepted but not yet delivered, oldest first.
  if_id_payload_t sb_q[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() != 0) begin
        check("sb.head_valid", bus.out_valid, 1'b1);
        check("sb.head_pc",    bus.out_pc, sb_q[0].pc);
        check("sb.head_ins",   bus.out_ins, sb_q[0].ins);
      end else begin
        check("sb.idle_valid", bus.out_valid, 1'b0);
        check("sb.idle_ins",   bus.out_ins, NOP_INSN);
        check("sb.idle_pc",    bus.out_pc, 64'h0);
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (bus.out_valid && !stall && sb_q.size() != 0) begin
          $display("txn deliver: pc=0x%0h ins=0x%08h", sb_q[0].pc, sb_q[0].ins);
          void'(sb_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
          sb_q.push_back(if_id_payload_t'{ins: bus.in_ins, pc: bus.in_pc});
        end
      end
      check("sb.occupancy", sb_q.size() <= 2, 1'b1);
    end
  end

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    offer(1'b0, 64'h0);
    tick();
    tick();
    expect_out("reset", 1'b0, 64'h0, 1'b1);
    reset_n = 1'b1;

`ifdef IF_ID_STALL_CNT_EN
    // Stall with nothing held does not count.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("cnt.empty_stall", stall_cnt, 32'd0);
    offer(1'b1, 64'h500);
    tick();
    offer(1'b0, 64'h0);
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b0;
    tick();
    check("cnt.five", stall_cnt, 32'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("cnt.hold", stall_cnt, 32'd5);
    stall = 1'b0;
    offer(1'b1, 64'h504);
    tick();
    offer(1'b0, 64'h0);
    stall = 1'b1;
    dut.stall_cnt_reg = 32'hFFFF_FFFF;
    tick();
    stall = 1'b0;
    check("cnt.wrap", stall_cnt, 32'd0);
    tick();
`endif

    // Streaming at full rate.
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 64'(4 * i));
      tick();
      expect_out("stream", 1'b1, 64'(4 * i), 1'b1);
    end
    offer(1'b0, 64'h0);
    tick();
    expect_out("stream_end", 1'b0, 64'h0, 1'b1);

    // Skid absorbs B while decode stalls on A.
    stall = 1'b1;
    offer(1'b1, 64'h10);
    tick();
    expect_out("skid_a", 1'b1, 64'h10, 1'b1);
    offer(1'b1, 64'h14);
    tick();
    expect_out("skid_b_absorbed", 1'b1, 64'h10, 1'b0);
    offer(1'b1, 64'h18);
    tick();
    expect_out("skid_full_hold", 1'b1, 64'h10, 1'b0);
    offer(1'b0, 64'h0);
    stall = 1'b0;
    tick();
    expect_out("skid_b_to_main", 1'b1, 64'h14, 1'b1);
    tick();
    expect_out("skid_drained", 1'b0, 64'h0, 1'b1);

    // Flush beats stall with two beats held.
    stall = 1'b1;
    offer(1'b1, 64'h100);
    tick();
    offer(1'b1, 64'h104);
    tick();
    expect_out("flush_pre", 1'b1, 64'h100, 1'b0);
    flush = 1'b1;
    offer(1'b1, 64'h20);
    tick();
    expect_out("flush_vs_stall", 1'b0, 64'h0, 1'b1);
    flush = 1'b0;
    stall = 1'b0;
    offer(1'b0, 64'h0);
    tick();
    expect_out("flush_empty", 1'b0, 64'h0, 1'b1);

    // Flush discards an accepted beat, next beat goes through.
    stall = 1'b1;
    offer(1'b1, 64'h200);
    tick();
    flush = 1'b1;
    offer(1'b1, 64'h28);
    tick();
    expect_out("flush_accept", 1'b0, 64'h0, 1'b1);
    flush = 1'b0;
    stall = 1'b0;
    offer(1'b1, 64'h40);
    tick();
    expect_out("post_flush_beat", 1'b1, 64'h40, 1'b1);
    offer(1'b0, 64'h0);
    tick();
    expect_out("post_flush_idle", 1'b0, 64'h0, 1'b1);

    // Asynchronous reset with two beats held.
    stall = 1'b1;
    offer(1'b1, 64'h300);
    tick();
    offer(1'b1, 64'h304);
    tick();
    offer(1'b0, 64'h0);
    expect_out("reset_pre", 1'b1, 64'h300, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("reset_async", 1'b0, 64'h0, 1'b1);
    tick();
    reset_n = 1'b1;
    stall   = 1'b0;
    tick();
    expect_out("reset_release", 1'b0, 64'h0, 1'b1);
    tick();
    tick();
    check("sb.drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
